// File: rtl/sc_fifo_if.sv
// sc_fifo bus: write data/request, read request, read data and status.
// master drives requests, slave (the FIFO) drives q/flags/usedw.
interface sc_fifo_if #(
  parameter int W  = 8,
  parameter int WU = 4
);
  logic [W-1:0]  data;
  logic          wrreq;
  logic          rdreq;
  logic [W-1:0]  q;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [WU-1:0] usedw;

  modport master (
    output data, wrreq, rdreq,
    input  q, empty, full,
    input  almost_full, almost_empty, usedw
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, empty, full,
    output almost_full, almost_empty, usedw
  );
endinterface

// File: rtl/sc_fifo.sv
// Single-clock FIFO, legacy or show-ahead read, with count/thresholds.
// Ports: clock, aclr_n (async low), sclr (sync), bus (sc_fifo_if.slave).
module sc_fifo #(
  parameter int lpm_width          = 8,
  parameter int lpm_widthu         = 4,
  parameter int lpm_numwords       = 16,
  parameter     lpm_showahead      = "OFF",
  parameter int almost_full_value  = 1,
  parameter int almost_empty_value = 1,
  parameter     overflow_checking  = "ON",
  parameter     underflow_checking = "ON",
  parameter     add_ram_output_register = "ON"
) (
  input logic     clock,
  input logic     aclr_n,
  input logic     sclr,
  sc_fifo_if.slave bus
);

  localparam int CW   = lpm_widthu + 1;
  localparam bit SHOW = (lpm_showahead == "ON");
  localparam bit OVF  = (overflow_checking == "ON");
  localparam bit UNF  = (underflow_checking == "ON");
  localparam logic [CW-1:0] DEPTH = CW'(lpm_numwords);
  localparam logic [CW-1:0] AFV   = CW'(almost_full_value);
  localparam logic [CW-1:0] AEV   = CW'(almost_empty_value);

  // Output register is always present; the hint only needs a legal value.
  if (add_ram_output_register != "ON" &&
      add_ram_output_register != "OFF") begin : g_bad_oreg
    $error("sc_fifo: bad add_ram_output_register");
  end
  if ((1 << lpm_widthu) != lpm_numwords) begin : g_bad_depth
    $error("sc_fifo: lpm_numwords must be 2**lpm_widthu");
  end

  logic [lpm_width-1:0]  mem [lpm_numwords];
  logic [lpm_widthu-1:0] wr_ptr;
  logic [lpm_widthu-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [lpm_width-1:0]  q_r;
  logic                  empty_i;
  logic                  full_i;
  logic                  wr_acc;
  logic                  rd_acc;

  assign empty_i = (count == '0);
  assign full_i  = (count == DEPTH);

  // Full gating deliberately ignores a same-cycle read.
  assign wr_acc = bus.wrreq && !(full_i && OVF);
  assign rd_acc = bus.rdreq && !(empty_i && UNF);

  always_ff @(posedge clock) begin
    if (wr_acc && !sclr) begin
      mem[wr_ptr] <= bus.data;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_r    <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_r    <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        q_r    <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Show-ahead presents the head word directly; zero while empty.
  assign bus.q = SHOW ? (empty_i ? '0 : mem[rd_ptr]) : q_r;

  assign bus.empty        = empty_i;
  assign bus.full         = full_i;
  assign bus.almost_full  = (count >= AFV);
  assign bus.almost_empty = (count < AEV);
  assign bus.usedw        = count[lpm_widthu-1:0];

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: legacy and show-ahead instances.
// Checks fill/drain, flags, simultaneous ops, wrap, sclr, aclr_n.
module tb_sc_fifo;

  logic clock;
  logic aclr_n;
  logic sclr_a;
  logic sclr_b;
  int   checks;
  int   errors;

  sc_fifo_if #(.W(16), .WU(4)) bus_a ();
  sc_fifo_if #(.W(16), .WU(4)) bus_b ();

  sc_fifo #(
    .lpm_width(16), .lpm_widthu(4), .lpm_numwords(16),
    .lpm_showahead("OFF"),
    .almost_full_value(3), .almost_empty_value(1)
  ) u_a (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr_a), .bus(bus_a)
  );

  sc_fifo #(
    .lpm_width(16), .lpm_widthu(4), .lpm_numwords(16),
    .lpm_showahead("ON"),
    .almost_full_value(3), .almost_empty_value(1)
  ) u_b (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr_b), .bus(bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_a(input logic [15:0] d);
    bus_a.data  = d;
    bus_a.wrreq = 1'b1;
    step();
    bus_a.wrreq = 1'b0;
  endtask

  task automatic rd_a();
    bus_a.rdreq = 1'b1;
    step();
    bus_a.rdreq = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    aclr_n = 1'b0;
    sclr_a = 1'b0;
    sclr_b = 1'b0;
    bus_a.data  = '0;
    bus_a.wrreq = 1'b0;
    bus_a.rdreq = 1'b0;
    bus_b.data  = '0;
    bus_b.wrreq = 1'b0;
    bus_b.rdreq = 1'b0;
    #1;
    chk("rst_empty", 32'(bus_a.empty), 1);
    chk("rst_full", 32'(bus_a.full), 0);
    chk("rst_usedw", 32'(bus_a.usedw), 0);
    chk("rst_q", 32'(bus_a.q), 0);
    chk("rst_af", 32'(bus_a.almost_full), 0);
    chk("rst_ae", 32'(bus_a.almost_empty), 1);
    #6;
    aclr_n = 1'b1;

    // fill 1..16, then a dropped 17th write
    for (int i = 1; i <= 16; i++) begin
      wr_a(16'(i));
      chk("fill_usedw", 32'(bus_a.usedw), 32'(i % 16));
      chk("fill_af", 32'(bus_a.almost_full), 32'(i >= 3));
      chk("fill_full", 32'(bus_a.full), 32'(i == 16));
    end
    wr_a(16'd99);
    chk("ovf_full", 32'(bus_a.full), 1);
    chk("ovf_usedw", 32'(bus_a.usedw), 0);

    // drain legacy
    for (int i = 1; i <= 16; i++) begin
      rd_a();
      chk("drain_q", 32'(bus_a.q), 32'(i));
      chk("drain_empty", 32'(bus_a.empty), 32'(i == 16));
    end
    rd_a();
    chk("unf_q", 32'(bus_a.q), 16);
    chk("unf_empty", 32'(bus_a.empty), 1);
    chk("unf_usedw", 32'(bus_a.usedw), 0);
    chk("unf_ae", 32'(bus_a.almost_empty), 1);

    // show-ahead
    bus_b.data  = 16'hA5A5;
    bus_b.wrreq = 1'b1;
    step();
    bus_b.wrreq = 1'b0;
    chk("sa_empty", 32'(bus_b.empty), 0);
    chk("sa_q", 32'(bus_b.q), 32'hA5A5);
    step();
    chk("sa_hold", 32'(bus_b.q), 32'hA5A5);
    bus_b.rdreq = 1'b1;
    step();
    bus_b.rdreq = 1'b0;
    chk("sa_pop", 32'(bus_b.empty), 1);

    // simultaneous with 5 words
    for (int i = 0; i < 5; i++) wr_a(16'(101 + i));
    for (int k = 0; k < 10; k++) begin
      bus_a.data  = 16'(106 + k);
      bus_a.wrreq = 1'b1;
      bus_a.rdreq = 1'b1;
      step();
      chk("sim_usedw", 32'(bus_a.usedw), 5);
      chk("sim_q", 32'(bus_a.q), 32'(101 + k));
    end
    bus_a.wrreq = 1'b0;
    bus_a.rdreq = 1'b0;
    for (int i = 0; i < 11; i++) wr_a(16'(116 + i));
    chk("sim_full", 32'(bus_a.full), 1);
    bus_a.data  = 16'd200;
    bus_a.wrreq = 1'b1;
    bus_a.rdreq = 1'b1;
    step();
    bus_a.wrreq = 1'b0;
    bus_a.rdreq = 1'b0;
    chk("fb_full", 32'(bus_a.full), 0);
    chk("fb_usedw", 32'(bus_a.usedw), 15);
    chk("fb_q", 32'(bus_a.q), 111);
    for (int i = 0; i < 15; i++) begin
      rd_a();
      chk("fb_drain_q", 32'(bus_a.q), 32'(112 + i));
    end
    chk("fb_empty", 32'(bus_a.empty), 1);

    // pointer wrap
    for (int k = 0; k < 40; k++) begin
      wr_a(16'(300 + k));
      rd_a();
      chk("wrap_q", 32'(bus_a.q), 32'(300 + k));
    end
    chk("wrap_empty", 32'(bus_a.empty), 1);

    // sclr with 7 words
    for (int i = 0; i < 7; i++) wr_a(16'(500 + i));
    chk("pre_sclr", 32'(bus_a.usedw), 7);
    sclr_a = 1'b1;
    step();
    sclr_a = 1'b0;
    chk("sclr_usedw", 32'(bus_a.usedw), 0);
    chk("sclr_empty", 32'(bus_a.empty), 1);
    chk("sclr_q", 32'(bus_a.q), 0);
    wr_a(16'd600);
    rd_a();
    chk("post_sclr_q", 32'(bus_a.q), 600);

    // async reset pulse mid-cycle
    for (int i = 0; i < 3; i++) wr_a(16'(700 + i));
    rd_a();
    chk("pre_aclr_q", 32'(bus_a.q), 700);
    #2;
    aclr_n = 1'b0;
    #1;
    chk("aclr_q", 32'(bus_a.q), 0);
    chk("aclr_usedw", 32'(bus_a.usedw), 0);
    chk("aclr_empty", 32'(bus_a.empty), 1);
    chk("aclr_full", 32'(bus_a.full), 0);
    chk("aclr_af", 32'(bus_a.almost_full), 0);
    chk("aclr_ae", 32'(bus_a.almost_empty), 1);
    chk("aclr_b_empty", 32'(bus_b.empty), 1);
    #2;
    aclr_n = 1'b1;
    wr_a(16'd800);
    rd_a();
    chk("post_aclr_q", 32'(bus_a.q), 800);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
